sad_search_ctrl: RTL and testbench
==================================

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 The block SHALL have the parameter FRAME_W, default 64, meaning frame width in pixels.
REQ-002 The block SHALL have the parameter FRAME_H, default 64, meaning frame height in pixels.
REQ-003 The block SHALL have the parameter WIN_W, default 4, meaning template window width.
REQ-004 The block SHALL have the parameter WIN_H, default 4, meaning template window height.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port Start, input, 1 bit: begin a full search.
REQ-008 The block SHALL have port SadReq, output, 1 bit: request a SAD computation from the datapath at CandX/CandY.
REQ-009 The block SHALL have ports CandX and CandY, output, 6 bits each: current candidate position.
REQ-010 The block SHALL have port SadValid, input, 1 bit: the datapath result on SadIn is valid.
REQ-011 The block SHALL have port SadIn, input, 32 bits: SAD result for the current candidate.
REQ-012 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port Done, output, 1 bit: one-cycle pulse when the search completes.
REQ-014 The block SHALL have ports MinX and MinY, output, 6 bits each: best position found.
REQ-015 The block SHALL have port MinSad, output, 32 bits: SAD at the best position.
REQ-016 The block SHALL have port Error, output, 1 bit: timeout flag (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-018 IDLE: Start=1 SHALL clear CandX, CandY and Error, SHALL set MinSad to 32'hFFFFFFFF, SHALL set MinX and MinY to 0, and SHALL go to ISSUE.
REQ-019 ISSUE: SadReq SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT; SadReq SHALL be 0 in all other states.
REQ-020 WAIT: the FSM SHALL hold until SadValid=1; on that cycle, if SadIn < MinSad (strict, unsigned), it SHALL load MinSad=SadIn, MinX=CandX and MinY=CandY.
REQ-021 Ties SHALL keep the earlier position, which is the first one in raster order.
REQ-022 Candidates SHALL be visited in raster order, X fastest: X runs 0..FRAME_W-WIN_W; on reaching the maximum X, X wraps to 0 and Y increments; Y runs 0..FRAME_H-WIN_H.
REQ-023 WAIT with SadValid=1 at the last candidate (both X and Y at their maximum) SHALL go to DONE; otherwise the FSM SHALL advance the position and go to ISSUE.
REQ-024 DONE SHALL assert Done=1 for one cycle, then the FSM SHALL go to IDLE; MinX, MinY and MinSad SHALL hold until the next Start.
REQ-025 Latency per candidate SHALL be 1 cycle plus the datapath response time; minimum 2 cycles when SadValid returns in the cycle after SadReq.
REQ-026 Start while Busy=1 SHALL be ignored.
REQ-027 SadValid outside WAIT SHALL be ignored.
REQ-028 Start asserted in the same cycle that Done is high SHALL be ignored.
REQ-029 A new search SHALL require Start=1 in IDLE.
REQ-030 The block SHALL reject at elaboration any parameters with FRAME_W-WIN_W > 63 or FRAME_H-WIN_H > 63.

Reset
REQ-031 Reset=0 SHALL asynchronously force state IDLE, CandX=CandY=0, MinX=MinY=0, MinSad=32'hFFFFFFFF, and SadReq=Busy=Done=Error=0.
REQ-032 Reset asserted mid-search SHALL abort the search with no Done pulse.
REQ-033 After reset release, the first Start SHALL begin from position (0,0).

Configuration
REQ-034 With SAD_TIMEOUT_EN defined, an 8-bit counter SHALL run in WAIT, cleared on entry to WAIT.
REQ-035 With SAD_TIMEOUT_EN defined, if 255 cycles elapse without SadValid, the candidate SHALL be skipped, the Min registers SHALL be left unchanged, Error SHALL be set sticky until the next accepted Start, and the FSM SHALL advance as if SadValid had arrived.
REQ-036 With SAD_TIMEOUT_EN undefined, WAIT SHALL wait indefinitely, Error SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-037 Scenario 1: FRAME_W=FRAME_H=8, WIN=4, SadIn=100 everywhere except (3,2), which returns 7 -> 25 SadReq pulses, Done once, MinX=3, MinY=2, MinSad=7.
REQ-038 Scenario 2: All SadIn=50 -> MinX=0, MinY=0, MinSad=50 (tie keeps the first position).
REQ-039 Scenario 3: Start pulsed again at candidate 10 of a running search -> ignored; 25 SadReq pulses total and a single Done.
REQ-040 Scenario 4: Reset=0 asserted during WAIT at (2,1) -> SadReq=Busy=0 immediately, no Done; the next Start's first CandX/CandY=(0,0).
REQ-041 Scenario 5: SadValid pulses while IDLE and during ISSUE -> no change to the Min registers and no state advance.
REQ-042 Scenario 6 (SAD_TIMEOUT_EN): SadValid withheld at (1,0) -> after 255 cycles Error=1, CandX=2; the search still completes with Done and the Min registers exclude (1,0).

Source files
------------

// File: rtl/sad_search_ctrl.sv
//==============================================================================
// Module  : sad_search_ctrl
// Purpose : Raster-order SAD minimum-search controller. Optional WAIT timeout
//           is enabled with the SAD_TIMEOUT_EN macro.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module sad_search_ctrl #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN_W   = 4,
  parameter int WIN_H   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic        SadReq,
  output logic [5:0]  CandX,
  output logic [5:0]  CandY,
  input  logic        SadValid,
  input  logic [31:0] SadIn,
  output logic        Busy,
  output logic        Done,
  output logic [5:0]  MinX,
  output logic [5:0]  MinY,
  output logic [31:0] MinSad,
  output logic        Error
);

  localparam int         c_X_SPAN = FRAME_W - WIN_W;
  localparam int         c_Y_SPAN = FRAME_H - WIN_H;
  localparam logic [5:0] c_X_MAX  = 6'(c_X_SPAN);
  localparam logic [5:0] c_Y_MAX  = 6'(c_Y_SPAN);

  // Candidate coordinates are 6 bits wide, so the search span must fit.
  generate
    if (c_X_SPAN > 63 || c_Y_SPAN > 63 || c_X_SPAN < 0 || c_Y_SPAN < 0) begin : g_bad_geometry
      $error("sad_search_ctrl: search span does not fit the 6-bit candidate range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cand_x;
  logic [5:0]  r_cand_y;
  logic [5:0]  r_min_x;
  logic [5:0]  r_min_y;
  logic [31:0] r_min_sad;
  logic        w_start_acc;
  logic        w_advance;
  logic        w_last;
  logic        w_timeout;

  assign w_last = (r_cand_x == c_X_MAX) && (r_cand_y == c_Y_MAX);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (SadValid || w_timeout) begin
          w_advance   = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A timed-out candidate advances without a result, so only SadValid may update the minimum.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_min_x   <= '0;
      r_min_y   <= '0;
      r_min_sad <= 32'hFFFF_FFFF;
    end else if (w_start_acc) begin
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_min_x   <= '0;
      r_min_y   <= '0;
      r_min_sad <= 32'hFFFF_FFFF;
    end else if (w_advance) begin
      if (SadValid && (SadIn < r_min_sad)) begin
        r_min_sad <= SadIn;
        r_min_x   <= r_cand_x;
        r_min_y   <= r_cand_y;
      end
      if (r_cand_x == c_X_MAX) begin
        r_cand_x <= '0;
        r_cand_y <= (r_cand_y == c_Y_MAX) ? 6'd0 : r_cand_y + 6'd1;
      end else begin
        r_cand_x <= r_cand_x + 6'd1;
      end
    end
  end

`ifdef SAD_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_error;

  // Count 254 is the 255th WAIT cycle; giving up there means 255 cycles passed without a result.
  assign w_timeout = (r_state == S_WAIT) && !SadValid && (r_to_cnt == 8'd254);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_to_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_to_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
      if (w_start_acc) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign Error = r_error;
`else
  assign w_timeout = 1'b0;
  assign Error     = 1'b0;
`endif

  assign SadReq = (r_state == S_ISSUE);
  assign Busy   = (r_state != S_IDLE);
  assign Done   = (r_state == S_DONE);
  assign CandX  = r_cand_x;
  assign CandY  = r_cand_y;
  assign MinX   = r_min_x;
  assign MinY   = r_min_y;
  assign MinSad = r_min_sad;

endmodule

`default_nettype wire

// File: tb/tb_sad_search_ctrl.sv
//==============================================================================
// Module  : tb_sad_search_ctrl
// Purpose : Scoreboard bench for sad_search_ctrl on an 8x8 frame, 4x4 window.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module tb_sad_search_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        SadReq;
  logic [5:0]  CandX;
  logic [5:0]  CandY;
  logic        SadValid;
  logic [31:0] SadIn;
  logic        Busy;
  logic        Done;
  logic [5:0]  MinX;
  logic [5:0]  MinY;
  logic [31:0] MinSad;
  logic        Error;

  always #5 Clk = ~Clk;

  sad_search_ctrl #(
    .FRAME_W(8),
    .FRAME_H(8),
    .WIN_W  (4),
    .WIN_H  (4)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .SadReq  (SadReq),
    .CandX   (CandX),
    .CandY   (CandY),
    .SadValid(SadValid),
    .SadIn   (SadIn),
    .Busy    (Busy),
    .Done    (Done),
    .MinX    (MinX),
    .MinY    (MinY),
    .MinSad  (MinSad),
    .Error   (Error)
  );

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [31:0] sad;
    int          reqs;
    int          cycles;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mode = 0;
  int   lat_rand = 0;
  int   glitch = 0;
  int   skip_en = 0;
  int   cyc = 0;
  int   req_cnt = 0;
  int   first_req = 0;
  int   done_cnt = 0;
  int   pushed = 0;
  logic [5:0] rx;
  logic [5:0] ry;
  int   n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-built SAD maps over the 5x5 candidate grid.
  function automatic logic [31:0] sad_of(input int m, input int x, input int y);
    case (m)
      0:       return (x == 3 && y == 2) ? 32'd7 : 32'd100;
      1:       return 32'd50;
      2:       return 32'((x - 2) * (x - 2) + 2 * (y - 3) * (y - 3) + 10);
      4:       return ((x == 1 && y == 1) || (x == 3 && y == 4)) ? 32'd5 : 32'd9;
      5:       return 32'(100 - x - 5 * y);
      6:       return 32'hFFFF_FFFF;
      7:       return (x == 1 && y == 0) ? 32'd1 : ((x == 3 && y == 3) ? 32'd20 : 32'd100);
      default: return 32'd0;
    endcase
  endfunction

  // Datapath model: answers each SadReq after 1..3 cycles.
  initial begin
    SadValid = 1'b0;
    SadIn    = '0;
    forever begin
      @(posedge Clk); #1;
      while (SadReq) begin
        rx = CandX;
        ry = CandY;
        if (glitch != 0) begin
          SadValid = 1'b1;
          SadIn    = '0;
        end else begin
          SadValid = 1'b0;
        end
        if (skip_en != 0 && rx == 6'd1 && ry == 6'd0) begin
          @(posedge Clk); #1;
          SadValid = 1'b0;
          break;
        end
        n = (lat_rand != 0) ? int'($urandom_range(1, 3)) : 1;
        for (int k = 1; k < n; k++) begin
          @(posedge Clk); #1;
          SadValid = 1'b0;
        end
        @(posedge Clk); #1;
        SadValid = 1'b1;
        SadIn    = sad_of(mode, int'(rx), int'(ry));
        @(posedge Clk); #1;
        SadValid = 1'b0;
      end
    end
  end

  // Monitor: counts requests and scores each Done against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk); #1;
      cyc++;
      if (!Busy) req_cnt = 0;
      if (SadReq) begin
        if (req_cnt == 0) first_req = cyc;
        req_cnt++;
      end
      if (Done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done=1 required no pending search");
        end else begin
          e = sb.pop_front();
          check("min_x", 32'(MinX), 32'(e.x));
          check("min_y", 32'(MinY), 32'(e.y));
          check("min_sad", MinSad, e.sad);
          check("sadreq_count", 32'(req_cnt), 32'(e.reqs));
          check("error_flag", 32'(Error), 32'(e.err));
          if (e.cycles != 0) check("search_latency", 32'(cyc - first_req), 32'(e.cycles));
        end
      end
    end
  end

  task automatic start_search(input int m, input int lr, input logic [5:0] ex, input logic [5:0] ey,
                              input logic [31:0] es, input int ecyc, input logic eerr);
    mode     = m;
    lat_rand = lr;
    sb.push_back('{x: ex, y: ey, sad: es, reqs: 25, cycles: ecyc, err: eerr});
    pushed++;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((sb.size() != 0 || Busy) && t < 3000) begin
      @(posedge Clk); #1;
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s_no_done: got pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    Reset = 1'b0;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_sadreq", 32'(SadReq), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_cand", {20'd0, CandX, CandY}, 32'd0);
    check("rst_min_xy", {20'd0, MinX, MinY}, 32'd0);
    check("rst_min_sad", MinSad, 32'hFFFF_FFFF);
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Single minimum at (3,2), fixed 1-cycle datapath: 50 cycles from first request to Done.
    start_search(0, 0, 6'd3, 6'd2, 32'd7, 50, 1'b0);
    wait_idle("s1");

    // All equal: the first position wins.
    start_search(1, 1, 6'd0, 6'd0, 32'd50, 0, 1'b0);
    wait_idle("s2");

    // Start pulsed at candidate 10 and again while Done is high.
    start_search(2, 0, 6'd2, 6'd3, 32'd10, 50, 1'b0);
    t = 0;
    while (!(SadReq && CandX == 6'd0 && CandY == 6'd2) && t < 500) begin
      @(posedge Clk); #1;
      t++;
    end
    check("s3_reach_cand10", 32'(t < 500), 32'd1);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    t = 0;
    while (!Done && t < 500) begin
      @(posedge Clk); #1;
      t++;
    end
    check("s3_reach_done", 32'(t < 500), 32'd1);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("s3_start_in_done_ignored", 32'(Busy), 32'd0);
    wait_idle("s3");

    // Reset during WAIT at (2,1): abort with no Done.
    mode     = 0;
    lat_rand = 0;
    Start    = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    t = 0;
    while (!(Busy && !SadReq && CandX == 6'd2 && CandY == 6'd1) && t < 500) begin
      @(posedge Clk); #1;
      t++;
    end
    check("s4_reach_wait21", 32'(t < 500), 32'd1);
    Reset = 1'b0;
    #1;
    check("s4_sadreq", 32'(SadReq), 32'd0);
    check("s4_busy", 32'(Busy), 32'd0);
    check("s4_cand", {20'd0, CandX, CandY}, 32'd0);
    check("s4_min_sad", MinSad, 32'hFFFF_FFFF);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("s4_done_count", 32'(done_cnt), 32'(pushed));
    start_search(5, 1, 6'd4, 6'd4, 32'd76, 0, 1'b0);
    check("s4_first_req", 32'(SadReq), 32'd1);
    check("s4_first_cand", {20'd0, CandX, CandY}, 32'd0);
    wait_idle("s4");

    // Stray SadValid during ISSUE, then while IDLE.
    glitch = 1;
    start_search(4, 0, 6'd1, 6'd1, 32'd5, 50, 1'b0);
    wait_idle("s5");
    glitch = 0;
    SadValid = 1'b1;
    SadIn    = '0;
    repeat (4) @(posedge Clk);
    #1;
    SadValid = 1'b0;
    check("s5_idle_busy", 32'(Busy), 32'd0);
    check("s5_idle_min_sad", MinSad, 32'd5);
    check("s5_idle_min_xy", {20'd0, MinX, MinY}, {20'd0, 6'd1, 6'd1});

    // Every result equals the reset value: strict compare never updates.
    start_search(6, 0, 6'd0, 6'd0, 32'hFFFF_FFFF, 50, 1'b0);
    wait_idle("s6");

`ifdef SAD_TIMEOUT_EN
    skip_en = 1;
    start_search(7, 0, 6'd3, 6'd3, 32'd20, 0, 1'b1);
    t = 0;
    while (!(SadReq && CandX == 6'd2 && CandY == 6'd0) && t < 400) begin
      @(posedge Clk); #1;
      t++;
    end
    check("to_reach_cand2", 32'(t < 400), 32'd1);
    check("to_error_set", 32'(Error), 32'd1);
    wait_idle("to");
    skip_en = 0;
    start_search(6, 0, 6'd0, 6'd0, 32'hFFFF_FFFF, 50, 1'b0);
    wait_idle("to_clear");
`endif

    check("total_done_count", 32'(done_cnt), 32'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
